// File: rtl/instr_sequencer_if.sv
// Instruction fetch bus between the sequencer and the instruction ROM.
// Request is held with a stable address until the ROM acks with data.
interface instr_sequencer_if #(
  parameter int PC_W = 5
);
  logic            I_req;
  logic [PC_W-1:0] I_addr;
  logic            I_ack;
  logic [15:0]     I_data;

  modport master (
    output I_req,
    output I_addr,
    input  I_ack,
    input  I_data
  );

  modport slave (
    input  I_req,
    input  I_addr,
    output I_ack,
    output I_data
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller driving the
// register-file / ALU / data-memory datapath control inputs.
module instr_sequencer #(
  parameter int              PC_W     = 5,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                i_Run,
  instr_sequencer_if.master   fb,
  output logic [7:0]          o_D_addr,
  output logic                o_D_wr,
  output logic                o_RF_s,
  output logic [3:0]          o_RF_W_addr,
  output logic                o_RF_W_wr,
  output logic [3:0]          o_RF_Ra_addr,
  output logic                o_RF_Ra_rd,
  output logic [3:0]          o_RF_Rb_addr,
  output logic                o_RF_Rb_rd,
  output logic [2:0]          o_Alu_s0,
  output logic [15:0]         o_IR_Out,
  output logic [PC_W-1:0]     o_PC_Out,
  output logic [3:0]          o_StateO,
  output logic                o_Halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_next;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic            w_take;

  assign w_take = (r_state == S_FETCH) && fb.I_ack;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_INIT;
      r_pc    <= START_PC;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_ir <= fb.I_data;
        r_pc <= r_pc + PC_ONE;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INIT:   if (i_Run) w_next = S_FETCH;
      S_FETCH:  if (fb.I_ack) w_next = S_DECODE;
      S_DECODE: begin
        unique case (r_ir[15:12])
          4'h1:    w_next = S_LOAD_A;
          4'h2:    w_next = S_STORE;
          4'h3:    w_next = S_ADD;
          4'h4:    w_next = S_SUB;
          4'h5:    w_next = S_HALT;
          default: w_next = S_NOOP;
        endcase
      end
      S_LOAD_A: w_next = S_LOAD_B;
      S_NOOP,
      S_LOAD_B,
      S_STORE,
      S_ADD,
      S_SUB:    w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_INIT;
    endcase
  end

  always_comb begin
    fb.I_req     = 1'b0;
    fb.I_addr    = '0;
    o_D_addr     = '0;
    o_D_wr       = 1'b0;
    o_RF_s       = 1'b0;
    o_RF_W_addr  = '0;
    o_RF_W_wr    = 1'b0;
    o_RF_Ra_addr = '0;
    o_RF_Ra_rd   = 1'b0;
    o_RF_Rb_addr = '0;
    o_RF_Rb_rd   = 1'b0;
    o_Alu_s0     = 3'b000;
    o_Halted     = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        fb.I_req  = 1'b1;
        fb.I_addr = r_pc;
      end
      // memory read is synchronous: address in A, write-back in B
      S_LOAD_A: begin
        o_D_addr = r_ir[11:4];
        o_RF_s   = 1'b1;
      end
      S_LOAD_B: begin
        o_D_addr    = r_ir[11:4];
        o_RF_s      = 1'b1;
        o_RF_W_addr = r_ir[3:0];
        o_RF_W_wr   = 1'b1;
      end
      S_STORE: begin
        o_D_addr     = r_ir[7:0];
        o_RF_Ra_addr = r_ir[11:8];
        o_RF_Ra_rd   = 1'b1;
        o_D_wr       = 1'b1;
      end
      S_ADD,
      S_SUB: begin
        o_RF_Ra_addr = r_ir[11:8];
        o_RF_Ra_rd   = 1'b1;
        o_RF_Rb_addr = r_ir[7:4];
        o_RF_Rb_rd   = 1'b1;
        o_RF_W_addr  = r_ir[3:0];
        o_RF_W_wr    = 1'b1;
        o_Alu_s0     = (r_state == S_ADD) ? 3'b001 : 3'b010;
      end
      S_HALT: o_Halted = 1'b1;
      default: ;
    endcase
  end

  assign o_IR_Out = r_ir;
  assign o_PC_Out = r_pc;
  assign o_StateO = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: fetch handshake, decode,
// execute control strobes, PC wrap and asynchronous reset.
module tb_instr_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Run;
  logic [7:0]  D_addr;
  logic        D_wr, RF_s, W_wr, Ra_rd, Rb_rd, Halted;
  logic [3:0]  W_addr, Ra_addr, Rb_addr, StateO;
  logic [2:0]  Alu;
  logic [15:0] IR;
  logic [4:0]  PC;

  int vec  = 0;
  int errs = 0;

  instr_sequencer_if #(.PC_W(5)) ifc ();

  instr_sequencer #(.PC_W(5), .START_PC(5'd0)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .i_Run        (Run),
    .fb           (ifc.master),
    .o_D_addr     (D_addr),
    .o_D_wr       (D_wr),
    .o_RF_s       (RF_s),
    .o_RF_W_addr  (W_addr),
    .o_RF_W_wr    (W_wr),
    .o_RF_Ra_addr (Ra_addr),
    .o_RF_Ra_rd   (Ra_rd),
    .o_RF_Rb_addr (Rb_addr),
    .o_RF_Rb_rd   (Rb_rd),
    .o_Alu_s0     (Alu),
    .o_IR_Out     (IR),
    .o_PC_Out     (PC),
    .o_StateO     (StateO),
    .o_Halted     (Halted)
  );

  always #5 Clk = ~Clk;

  task automatic clk1();
    @(posedge Clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] w);
    ifc.I_ack  = 1'b1;
    ifc.I_data = w;
    clk1();
    ifc.I_ack  = 1'b0;
    ifc.I_data = 16'h0000;
  endtask

  // leaves the DUT in FETCH at PC=0 with Run high
  task automatic do_reset();
    Reset = 1'b1;
    Run = 1'b0;
    ifc.I_ack = 1'b0;
    ifc.I_data = 16'h0;
    clk1();
    Reset = 1'b0;
    Run = 1'b1;
    clk1();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Run = 1'b0;
    ifc.I_ack = 1'b0;
    ifc.I_data = 16'h0;
    clk1();
    vec++;
    if (StateO !== 4'd0 || PC !== 5'd0 || IR !== 16'h0) begin
      errs++;
      $display("FAIL reset_regs st=%0d pc=%0d ir=%h exp 0/0/0",
               StateO, PC, IR);
    end
    vec++;
    if ({ifc.I_req, D_wr, W_wr, Ra_rd, Rb_rd, RF_s, Halted}
        !== 7'b0 || Alu !== 3'b0) begin
      errs++;
      $display("FAIL reset_strobes req=%b alu=%b exp 0",
               ifc.I_req, Alu);
    end
    Reset = 1'b0;
    clk1();
    clk1();
    vec++;
    if (StateO !== 4'd0) begin
      errs++;
      $display("FAIL init_hold st=%0d exp 0", StateO);
    end
  endtask

  task automatic test_basic();
    Run = 1'b1;
    clk1();
    vec++;
    if (StateO !== 4'd1 || ifc.I_req !== 1'b1 ||
        ifc.I_addr !== 5'd0) begin
      errs++;
      $display("FAIL basic_fetch st=%0d req=%b addr=%0d exp 1/1/0",
               StateO, ifc.I_req, ifc.I_addr);
    end
    fetch(16'h0000);
    vec++;
    if (StateO !== 4'd2 || PC !== 5'd1) begin
      errs++;
      $display("FAIL basic_decode st=%0d pc=%0d exp 2/1",
               StateO, PC);
    end
    clk1();
    vec++;
    if (StateO !== 4'd3 || {D_wr, W_wr, Ra_rd, Rb_rd} !== 4'b0) begin
      errs++;
      $display("FAIL basic_noop st=%0d wr=%b%b exp 3 no strobes",
               StateO, D_wr, W_wr);
    end
    clk1();
    vec++;
    if (StateO !== 4'd1 || ifc.I_addr !== 5'd1) begin
      errs++;
      $display("FAIL basic_refetch st=%0d addr=%0d exp 1/1",
               StateO, ifc.I_addr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    ifc.I_data = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      clk1();
      vec++;
      if (StateO !== 4'd1 || ifc.I_req !== 1'b1 ||
          ifc.I_addr !== 5'd0 || IR !== 16'h0) begin
        errs++;
        $display("FAIL stall_%0d st=%0d req=%b addr=%0d ir=%h exp 1/1/0/0",
                 i, StateO, ifc.I_req, ifc.I_addr, IR);
      end
    end
    fetch(16'h1234);
    vec++;
    if (IR !== 16'h1234 || StateO !== 4'd2) begin
      errs++;
      $display("FAIL stall_ack ir=%h st=%0d exp 1234/2", IR, StateO);
    end
  endtask

  task automatic test_program();
    do_reset();
    fetch(16'h1A53);
    clk1();
    vec++;
    if (StateO !== 4'd4 || D_addr !== 8'hA5 || RF_s !== 1'b1 ||
        W_wr !== 1'b0) begin
      errs++;
      $display("FAIL load_a st=%0d da=%h s=%b wr=%b exp 4/a5/1/0",
               StateO, D_addr, RF_s, W_wr);
    end
    clk1();
    vec++;
    if (StateO !== 4'd5 || W_wr !== 1'b1 || W_addr !== 4'd3 ||
        RF_s !== 1'b1 || D_addr !== 8'hA5) begin
      errs++;
      $display("FAIL load_b st=%0d wr=%b wa=%0d exp 5/1/3",
               StateO, W_wr, W_addr);
    end
    clk1();
    fetch(16'h3345);
    clk1();
    vec++;
    if (StateO !== 4'd7 || Ra_addr !== 4'd3 || Rb_addr !== 4'd4 ||
        W_addr !== 4'd5 || Alu !== 3'b001 || W_wr !== 1'b1 ||
        Ra_rd !== 1'b1 || Rb_rd !== 1'b1 || RF_s !== 1'b0) begin
      errs++;
      $display("FAIL add st=%0d ra=%0d rb=%0d w=%0d alu=%b exp 7/3/4/5/001",
               StateO, Ra_addr, Rb_addr, W_addr, Alu);
    end
    clk1();
    fetch(16'h2506);
    clk1();
    vec++;
    if (StateO !== 4'd6 || D_addr !== 8'h06 || Ra_addr !== 4'd5 ||
        D_wr !== 1'b1 || Ra_rd !== 1'b1 || W_wr !== 1'b0) begin
      errs++;
      $display("FAIL store st=%0d da=%h ra=%0d dwr=%b exp 6/06/5/1",
               StateO, D_addr, Ra_addr, D_wr);
    end
    clk1();
    vec++;
    if (StateO !== 4'd1 || PC !== 5'd3) begin
      errs++;
      $display("FAIL prog_end st=%0d pc=%0d exp 1/3", StateO, PC);
    end
  endtask

  task automatic test_sub_undef_halt();
    fetch(16'h4123);
    clk1();
    vec++;
    if (StateO !== 4'd8 || Alu !== 3'b010 || W_addr !== 4'd3 ||
        Ra_addr !== 4'd1 || Rb_addr !== 4'd2 || W_wr !== 1'b1) begin
      errs++;
      $display("FAIL sub st=%0d alu=%b w=%0d exp 8/010/3",
               StateO, Alu, W_addr);
    end
    clk1();
    fetch(16'hF000);
    clk1();
    vec++;
    if (StateO !== 4'd3 ||
        {D_wr, W_wr, Ra_rd, Rb_rd, RF_s} !== 5'b0) begin
      errs++;
      $display("FAIL undef st=%0d dwr=%b wwr=%b exp 3 no strobes",
               StateO, D_wr, W_wr);
    end
    clk1();
    fetch(16'h5000);
    clk1();
    for (int i = 0; i < 20; i++) begin
      vec++;
      if (StateO !== 4'd9 || Halted !== 1'b1 ||
          ifc.I_req !== 1'b0) begin
        errs++;
        $display("FAIL halt_%0d st=%0d h=%b req=%b exp 9/1/0",
                 i, StateO, Halted, ifc.I_req);
      end
      Run = ~Run;
      ifc.I_ack = Run;
      clk1();
    end
    ifc.I_ack = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      vec++;
      if (StateO !== 4'd1 || ifc.I_addr !== 5'(i)) begin
        errs++;
        $display("FAIL wrap_addr_%0d st=%0d addr=%0d exp 1/%0d",
                 i, StateO, ifc.I_addr, i);
      end
      fetch(16'h0000);
      clk1();
      clk1();
    end
    vec++;
    if (PC !== 5'd0 || ifc.I_addr !== 5'd0 || StateO !== 4'd1) begin
      errs++;
      $display("FAIL wrap_end pc=%0d addr=%0d st=%0d exp 0/0/1",
               PC, ifc.I_addr, StateO);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch(16'h0000);
    clk1();
    clk1();
    #1 Reset = 1'b1;
    #1;
    vec++;
    if (StateO !== 4'd0 || ifc.I_req !== 1'b0 ||
        ifc.I_addr !== 5'd0 || PC !== 5'd0) begin
      errs++;
      $display("FAIL arst_fetch st=%0d req=%b pc=%0d exp 0/0/0",
               StateO, ifc.I_req, PC);
    end
    Reset = 1'b0;
    clk1();
    fetch(16'h3345);
    clk1();
    vec++;
    if (StateO !== 4'd7) begin
      errs++;
      $display("FAIL arst_pre_add st=%0d exp 7", StateO);
    end
    #1 Reset = 1'b1;
    #1;
    vec++;
    if (StateO !== 4'd0 || IR !== 16'h0 || PC !== 5'd0 ||
        {W_wr, Ra_rd, Rb_rd, D_wr, RF_s} !== 5'b0 ||
        W_addr !== 4'd0 || Ra_addr !== 4'd0 || Rb_addr !== 4'd0 ||
        Alu !== 3'b000) begin
      errs++;
      $display("FAIL arst_add st=%0d ir=%h pc=%0d alu=%b wwr=%b exp 0",
               StateO, IR, PC, Alu, W_wr);
    end
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_program();
    test_sub_undef_halt();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
